// File: rtl/ws_act_skew_feeder.sv
// Activation skew feeder for the weight-stationary array: widens int8 rows, skews row r by r cycles.
// Optional WS_SKEW_INPUT_OFFSET_EN adds a per-tile signed input_offset (zero-point) to each accepted element.
module ws_act_skew_feeder #(
    parameter int SIZE = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SIZE-1:0][7:0]   in_data,
    input  logic                   in_last,
`ifdef WS_SKEW_INPUT_OFFSET_EN
    input  logic [8:0]             input_offset,
`endif
    output logic [SIZE-1:0][15:0]  data_out,
    output logic [SIZE-1:0]        row_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    accept;
    logic [SIZE-1:0][15:0]   widened;

    assign in_ready = rst_n && (state_q != DRAIN);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    always_comb begin
        for (int r = 0; r < SIZE; r++) begin
`ifdef WS_SKEW_INPUT_OFFSET_EN
            widened[r] = {{8{in_data[r][7]}}, in_data[r]} + {{7{input_offset[8]}}, input_offset};
`else
            widened[r] = {{8{in_data[r][7]}}, in_data[r]};
`endif
        end
    end

    // The drain counter reaches zero exactly when row SIZE-1 presents the last vector.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_last) begin
                        state_d = DRAIN;
                        cnt_d   = CW'(SIZE - 1);
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (accept && in_last) begin
                    state_d = DRAIN;
                    cnt_d   = CW'(SIZE - 1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DRAIN) && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Triangular skew: row r owns a chain of r+1 stages; bubbles enter as zero with valid low.
    for (genvar r = 0; r < SIZE; r++) begin : g_row
        logic [15:0] data_q [0:r];
        logic [r:0]  valid_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int s = 0; s <= r; s++) begin
                    data_q[s] <= '0;
                end
                valid_q <= '0;
            end else begin
                data_q[0]  <= accept ? widened[r] : 16'd0;
                valid_q[0] <= accept;
                for (int s = 1; s <= r; s++) begin
                    data_q[s]  <= data_q[s-1];
                    valid_q[s] <= valid_q[s-1];
                end
            end
        end

        assign data_out[r]  = data_q[r];
        assign row_valid[r] = valid_q[r];
    end

endmodule

// File: tb/tb_ws_act_skew_feeder.sv
// Scoreboard bench for ws_act_skew_feeder at SIZE=4; expected row outputs are queued per row at issue time.
// Define WS_SKEW_INPUT_OFFSET_EN to also run the zero-point offset vectors.
module tb_ws_act_skew_feeder;

    localparam int SIZE = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [SIZE-1:0][7:0]  in_data;
    logic                  in_last;
`ifdef WS_SKEW_INPUT_OFFSET_EN
    logic [8:0]            input_offset;
`endif
    logic [SIZE-1:0][15:0] data_out;
    logic [SIZE-1:0]       row_valid;
    logic                  busy;
    logic                  done;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          monEn = 0;
    logic [15:0] rowVal [SIZE][$];
    int          rowCyc [SIZE][$];
    int          doneQ [$];

    ws_act_skew_feeder #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
`ifdef WS_SKEW_INPUT_OFFSET_EN
        .input_offset (input_offset),
`endif
        .data_out  (data_out),
        .row_valid (row_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flagUnexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: output present with nothing expected (edge %0d)", name, cyc);
    endtask

    // Monitor: pops a row's expectation whenever that row presents valid data; idle rows must read zero.
    always @(negedge clk) begin
        if (monEn) begin
            for (int r = 0; r < SIZE; r++) begin
                if (row_valid[r] === 1'b1) begin
                    if (rowVal[r].size() == 0) begin
                        flagUnexpected($sformatf("row%0d valid", r));
                    end else begin
                        checkOutput($sformatf("row%0d data", r), data_out[r], rowVal[r].pop_front());
                        checkOutput($sformatf("row%0d timing", r), cyc, rowCyc[r].pop_front());
                    end
                end else begin
                    checkOutput($sformatf("row%0d zero when invalid", r), {row_valid[r], data_out[r]}, 0);
                end
            end
            if (done === 1'b1) begin
                if (doneQ.size() == 0) flagUnexpected("done pulse");
                else checkOutput("done timing", cyc, doneQ.pop_front());
            end
        end
    end

    // Called just after an edge; drives one cycle and queues expectations if a vector is offered.
    task automatic applyStimulus(input logic v, input logic [SIZE-1:0][7:0] d,
                                 input logic [SIZE-1:0][15:0] e, input logic last);
        in_valid = v;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        if (v) begin
            checkOutput("in_ready at offer", in_ready, 1);
            for (int r = 0; r < SIZE; r++) begin
                rowVal[r].push_back(e[r]);
                rowCyc[r].push_back(cyc + 1 + r);
            end
            if (last) doneQ.push_back(cyc + SIZE);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0);
    endtask

    task automatic checkDrain(input string name);
        int lowCnt;
        int busyLow;
        lowCnt  = 0;
        busyLow = 0;
        for (int i = 0; i < 3 * SIZE; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            lowCnt++;
            if (busy !== 1'b1) busyLow++;
        end
        checkOutput({name, " ready-low cycles"}, lowCnt, SIZE);
        checkOutput({name, " busy through drain"}, busyLow, 0);
        checkOutput({name, " idle busy"}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic flushScoreboard();
        for (int r = 0; r < SIZE; r++) begin
            rowVal[r].delete();
            rowCyc[r].delete();
        end
        doneQ.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [SIZE-1:0][7:0]  d;
        logic [SIZE-1:0][15:0] e;
        int remaining;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
`ifdef WS_SKEW_INPUT_OFFSET_EN
        input_offset = 9'd0;
`endif

        $display("[TB] reset and idle");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            monEn = 1'b1;
            checkOutput("reset in_ready", in_ready, 0);
            checkOutput("reset busy", busy, 0);
            checkOutput("reset done", done, 0);
            checkOutput("reset row_valid", row_valid, 0);
            checkOutput("reset data_out", data_out, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release in_ready", in_ready, 1);
        checkOutput("release busy", busy, 0);
        @(posedge clk);
        #1;

        $display("[TB] diagonal skew");
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < SIZE; r++) begin
                d[r] = 8'(10 * k + r);
                e[r] = 16'(10 * k + r);
            end
            applyStimulus(1'b1, d, e, k == 3);
            if (k == 0) checkOutput("stream busy", busy, 1);
        end
        checkDrain("diagonal");

        $display("[TB] bubbles");
        applyStimulus(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b0);
        idleCycle();
        idleCycle();
        applyStimulus(1'b1, {8'hFB, 8'hFA, 8'hF9, 8'hF8},
                      {16'hFFFB, 16'hFFFA, 16'hFFF9, 16'hFFF8}, 1'b1);
        checkDrain("bubble");

        $display("[TB] negative extension");
        applyStimulus(1'b1, {4{8'h80}}, {4{16'hFF80}}, 1'b1);
        checkDrain("negative");

        $display("[TB] reset mid-drain");
        applyStimulus(1'b1, {8'd44, 8'd33, 8'd22, 8'd11}, {16'd44, 16'd33, 16'd22, 16'd11}, 1'b1);
        idleCycle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        flushScoreboard();
        @(negedge clk);
        checkOutput("mid reset row_valid", row_valid, 0);
        checkOutput("mid reset data_out", data_out, 0);
        checkOutput("mid reset busy", busy, 0);
        checkOutput("mid reset in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < SIZE + 2; i++) idleCycle();
        applyStimulus(1'b1, {8'd7, 8'd6, 8'd5, 8'd9}, {16'd7, 16'd6, 16'd5, 16'd9}, 1'b1);
        checkDrain("after reset");

`ifdef WS_SKEW_INPUT_OFFSET_EN
        $display("[TB] input offset");
        input_offset = 9'd128;
        applyStimulus(1'b1, {8'hFF, 8'h00, 8'h7F, 8'h80}, {16'd127, 16'd128, 16'd255, 16'd0}, 1'b0);
        idleCycle();
        applyStimulus(1'b1, {8'h01, 8'h01, 8'h01, 8'h01}, {16'd129, 16'd129, 16'd129, 16'd129}, 1'b1);
        checkDrain("offset");
        input_offset = 9'd0;
`endif

        for (int i = 0; i < SIZE + 2; i++) idleCycle();
        remaining = doneQ.size();
        for (int r = 0; r < SIZE; r++) remaining += rowVal[r].size();
        checkOutput("scoreboard drained", remaining, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
